// File: rtl/bt656_pkg.sv
// Shared BT.656 timing-reference definitions for the sync decoder and the matching encoder.
// Holds the preamble bytes, the XY code table, the preamble FSM states and the protection function.
package bt656_pkg;

  localparam logic [7:0] ByteFf   = 8'hFF;
  localparam logic [7:0] ByteZero = 8'h00;

  // Indexed by {F, V, H}, so a code is valid only if it equals the entry its own flags select.
  localparam logic [7:0] XyCodes [8] = '{
    8'h80, 8'h9D, 8'hAB, 8'hB6, 8'hC7, 8'hDA, 8'hEC, 8'hF1
  };

  typedef enum logic [1:0] {
    StSeek,
    StFf1,
    StZ1,
    StZ2
  } pre_state_e;

  function automatic logic [3:0] fvh_to_p(input logic f, input logic v, input logic h);
    return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

endpackage

// File: rtl/bt656_sync_decoder_if.sv
// Byte-stream input and decoded timing/pixel outputs of the BT.656 sync decoder.
// The master side is the video source plus its consumer; the slave side is the decoder.
interface bt656_sync_decoder_if #(
  parameter int unsigned CNT_W = 16
);

  logic [7:0]       din;
  logic             din_en;
  logic [7:0]       pix;
  logic             pix_valid;
  logic             hd;
  logic             vd;
  logic             field;
  logic             sav_pulse;
  logic             eav_pulse;
  logic             prot_err;
  logic             seq_err;
  logic             len_err;
  logic [CNT_W-1:0] line_len;
  logic [CNT_W-1:0] line_cnt;
  logic             locked;

  modport master (
    output din, din_en,
    input  pix, pix_valid, hd, vd, field, sav_pulse, eav_pulse,
    input  prot_err, seq_err, len_err, line_len, line_cnt, locked
  );

  modport slave (
    input  din, din_en,
    output pix, pix_valid, hd, vd, field, sav_pulse, eav_pulse,
    output prot_err, seq_err, len_err, line_len, line_cnt, locked
  );

endinterface

// File: rtl/bt656_xy_check.sv
// Combinational XY validation and F/V/H extraction for a BT.656 timing-reference code.
module bt656_xy_check
  import bt656_pkg::*;
(
  input  logic [7:0] xy,
  output logic       f,
  output logic       v,
  output logic       h,
  output logic       valid
);

  assign f = xy[6];
  assign v = xy[5];
  assign h = xy[4];

  // Covers both the protection nibble and the mandatory XY[7]=1.
  assign valid = (xy == XyCodes[xy[6:4]]);

endmodule

// File: rtl/bt656_sync_decoder.sv
// BT.656 receive-side sync decoder: finds FF 00 00 XY codes, tracks F/V/H, strobes active
// pixels, measures line length, counts lines per field and reports lock and framing errors.
module bt656_sync_decoder
  import bt656_pkg::*;
#(
  parameter int unsigned ACTIVE_LEN = 7,
  parameter int unsigned LOCK_LINES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input logic                 clk,
  input logic                 rsted_n,
  bt656_sync_decoder_if.slave bus
);

  localparam int unsigned      GoodW     = $clog2(LOCK_LINES + 1);
  localparam logic [CNT_W-1:0] ActiveLen = CNT_W'(ACTIVE_LEN);
  localparam logic [GoodW-1:0] LockLines = GoodW'(LOCK_LINES);

  pre_state_e       state_q;
  logic             hd_q;
  logic             vd_q;
  logic             field_q;
  logic             brk_q;
  logic             pix_valid_q;
  logic             sav_q;
  logic             eav_q;
  logic             prot_q;
  logic             seq_q;
  logic             len_q;
  logic             locked_q;
  logic [7:0]       pix_q;
  logic [CNT_W-1:0] pix_cnt_q;
  logic [CNT_W-1:0] line_len_q;
  logic [CNT_W-1:0] line_cnt_q;
  logic [GoodW-1:0] good_q;

  logic [7:0] din;
  logic       din_en;
  logic       xy_f;
  logic       xy_v;
  logic       xy_h;
  logic       xy_valid;
  logic       is_ff;
  logic       is_zero;
  logic       pix_hit;
  logic       len_bad;
  logic       pre_fail;

  assign din    = bus.din;
  assign din_en = bus.din_en;

  bt656_xy_check u_xy_check (
    .xy    (din),
    .f     (xy_f),
    .v     (xy_v),
    .h     (xy_h),
    .valid (xy_valid)
  );

  assign is_ff    = (din == ByteFf);
  assign is_zero  = (din == ByteZero);
  assign pix_hit  = hd_q & ~vd_q & ~is_ff & ~is_zero;
  assign len_bad  = ~xy_v & (pix_cnt_q != ActiveLen);
  // A partial preamble that is neither continued by 00 nor restarted by FF.
  assign pre_fail = ((state_q == StFf1) | (state_q == StZ1)) & ~is_ff & ~is_zero;

  always_ff @(posedge clk or negedge rsted_n) begin
    if (!rsted_n) begin
      state_q     <= StSeek;
      hd_q        <= 1'b0;
      vd_q        <= 1'b1;
      field_q     <= 1'b0;
      brk_q       <= 1'b0;
      pix_valid_q <= 1'b0;
      sav_q       <= 1'b0;
      eav_q       <= 1'b0;
      prot_q      <= 1'b0;
      seq_q       <= 1'b0;
      len_q       <= 1'b0;
      locked_q    <= 1'b0;
      pix_q       <= '0;
      pix_cnt_q   <= '0;
      line_len_q  <= '0;
      line_cnt_q  <= '0;
      good_q      <= '0;
    end else begin
      pix_valid_q <= 1'b0;
      sav_q       <= 1'b0;
      eav_q       <= 1'b0;
      prot_q      <= 1'b0;
      seq_q       <= 1'b0;
      len_q       <= 1'b0;
      if (din_en) begin
        pix_q       <= din;
        pix_valid_q <= pix_hit;
        if (pix_hit && (pix_cnt_q != '1)) begin
          pix_cnt_q <= pix_cnt_q + 1'b1;
        end
        // FF inside the window ends it at once; brk_q remembers a code is now owed.
        if (hd_q && is_ff) begin
          hd_q  <= 1'b0;
          brk_q <= 1'b1;
        end
        if (pre_fail && brk_q) begin
          seq_q    <= 1'b1;
          brk_q    <= 1'b0;
          good_q   <= '0;
          locked_q <= 1'b0;
        end
        unique case (state_q)
          StSeek: begin
            if (is_ff) state_q <= StFf1;
          end
          StFf1: begin
            if (is_zero)     state_q <= StZ1;
            else if (!is_ff) state_q <= StSeek;
          end
          StZ1: begin
            if (is_zero)    state_q <= StZ2;
            else if (is_ff) state_q <= StFf1;
            else            state_q <= StSeek;
          end
          StZ2: begin
            state_q <= StSeek;
            brk_q   <= 1'b0;
            if (!xy_valid) begin
              prot_q   <= 1'b1;
              good_q   <= '0;
              locked_q <= 1'b0;
            end else if (!xy_h) begin
              sav_q     <= 1'b1;
              hd_q      <= 1'b1;
              pix_cnt_q <= '0;
              vd_q      <= xy_v;
              field_q   <= xy_f;
            end else begin
              eav_q   <= 1'b1;
              hd_q    <= 1'b0;
              vd_q    <= xy_v;
              field_q <= xy_f;
              len_q   <= len_bad;
              if (!xy_v) line_len_q <= pix_cnt_q;
              if (xy_f != field_q) begin
                line_cnt_q <= '0;
              end else if (line_cnt_q != '1) begin
                line_cnt_q <= line_cnt_q + 1'b1;
              end
              if (len_bad) begin
                good_q   <= '0;
                locked_q <= 1'b0;
              end else if (!xy_v && (good_q != LockLines)) begin
                good_q   <= good_q + 1'b1;
                locked_q <= ((good_q + 1'b1) == LockLines);
              end
            end
          end
          default: state_q <= StSeek;
        endcase
      end
    end
  end

  assign bus.pix       = pix_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.hd        = hd_q;
  assign bus.vd        = vd_q;
  assign bus.field     = field_q;
  assign bus.sav_pulse = sav_q;
  assign bus.eav_pulse = eav_q;
  assign bus.prot_err  = prot_q;
  assign bus.seq_err   = seq_q;
  assign bus.len_err   = len_q;
  assign bus.line_len  = line_len_q;
  assign bus.line_cnt  = line_cnt_q;
  assign bus.locked    = locked_q;

endmodule

// File: tb/tb_bt656_sync_decoder.sv
// Directed and randomized bench for bt656_sync_decoder against a byte-level reference model.
module tb_bt656_sync_decoder;

  logic clk = 1'b0;
  logic rsted_n;
  always #5 clk = ~clk;

  bt656_sync_decoder_if #(.CNT_W(16)) bus ();

  bt656_sync_decoder #(
    .ACTIVE_LEN (7),
    .LOCK_LINES (2),
    .CNT_W      (16)
  ) dut (
    .clk     (clk),
    .rsted_n (rsted_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  int gap_mode = 0;  // 0: din_en always 1, 1: strict 1/0 toggle, 2: random idle gaps

  int         n_sav, n_eav, n_pv, n_prot, n_seq;
  logic [7:0] got_pix [$];

  // Reference model state
  bit         m_hd, m_vd, m_field, m_brk, m_locked;
  bit         m_pv, m_sav, m_eav, m_prot, m_seq, m_len;
  logic [7:0] m_pix;
  int         m_line_len, m_line_cnt, m_good, m_pixcnt;
  logic [7:0] pre [$];

  function automatic bit code_ok(input logic [7:0] b);
    case (b)
      8'h80, 8'h9D, 8'hAB, 8'hB6, 8'hC7, 8'hDA, 8'hEC, 8'hF1: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_hd = 0; m_vd = 1; m_field = 0; m_brk = 0; m_locked = 0;
    m_pv = 0; m_sav = 0; m_eav = 0; m_prot = 0; m_seq = 0; m_len = 0;
    m_pix = 8'h00; m_line_len = 0; m_line_cnt = 0; m_good = 0; m_pixcnt = 0;
    pre.delete();
  endtask

  task automatic model_break_lock();
    m_good = 0;
    m_locked = 0;
  endtask

  task automatic model_code(input logic [7:0] b);
    bit f, v, h, bad;
    f = b[6]; v = b[5]; h = b[4];
    if (!code_ok(b)) begin
      m_prot = 1;
      model_break_lock();
    end else if (!h) begin
      m_sav = 1; m_hd = 1; m_pixcnt = 0; m_vd = v; m_field = f;
    end else begin
      m_eav = 1; m_hd = 0;
      bad = !v && (m_pixcnt != 7);
      m_len = bad;
      if (!v) m_line_len = m_pixcnt;
      if (f != m_field) m_line_cnt = 0;
      else if (m_line_cnt < 65535) m_line_cnt++;
      m_vd = v; m_field = f;
      if (bad) model_break_lock();
      else if (!v) begin
        if (m_good < 2) m_good++;
        if (m_good == 2) m_locked = 1;
      end
    end
  endtask

  task automatic model_step(input logic [7:0] b, input bit en);
    m_pv = 0; m_sav = 0; m_eav = 0; m_prot = 0; m_seq = 0; m_len = 0;
    if (en) begin
      m_pix = b;
      m_pv  = m_hd && !m_vd && (b != 8'hFF) && (b != 8'h00);
      if (m_pv && m_pixcnt < 65535) m_pixcnt++;
      if (m_hd && b == 8'hFF) begin
        m_hd = 0;
        m_brk = 1;
      end
      if (pre.size() == 3) begin
        pre.delete();
        m_brk = 0;
        model_code(b);
      end else if (b == 8'hFF) begin
        pre.delete();
        pre.push_back(b);
      end else if (b == 8'h00 && (pre.size() == 1 || pre.size() == 2)) begin
        pre.push_back(b);
      end else if (pre.size() != 0) begin
        pre.delete();
        if (m_brk) begin
          m_seq = 1;
          m_brk = 0;
          model_break_lock();
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("hd", 32'(bus.hd), 32'(m_hd));
    chk("vd", 32'(bus.vd), 32'(m_vd));
    chk("field", 32'(bus.field), 32'(m_field));
    chk("pix_valid", 32'(bus.pix_valid), 32'(m_pv));
    if (m_pv) chk("pix", 32'(bus.pix), 32'(m_pix));
    chk("sav_pulse", 32'(bus.sav_pulse), 32'(m_sav));
    chk("eav_pulse", 32'(bus.eav_pulse), 32'(m_eav));
    chk("prot_err", 32'(bus.prot_err), 32'(m_prot));
    chk("seq_err", 32'(bus.seq_err), 32'(m_seq));
    chk("len_err", 32'(bus.len_err), 32'(m_len));
    chk("line_len", 32'(bus.line_len), 32'(m_line_len));
    chk("line_cnt", 32'(bus.line_cnt), 32'(m_line_cnt));
    chk("locked", 32'(bus.locked), 32'(m_locked));
  endtask

  task automatic drive(input logic [7:0] b, input bit en);
    @(negedge clk);
    bus.din    = b;
    bus.din_en = en;
    @(posedge clk);
    #1;
    model_step(b, en);
    check_all();
    if (bus.sav_pulse) n_sav++;
    if (bus.eav_pulse) n_eav++;
    if (bus.prot_err)  n_prot++;
    if (bus.seq_err)   n_seq++;
    if (bus.pix_valid) begin
      n_pv++;
      got_pix.push_back(bus.pix);
    end
  endtask

  task automatic send(input logic [7:0] b);
    if (gap_mode == 1) drive(8'($urandom_range(0, 255)), 1'b0);
    if (gap_mode == 2) begin
      repeat ($urandom_range(0, 2)) drive(8'($urandom_range(0, 255)), 1'b0);
    end
    drive(b, 1'b1);
  endtask

  task automatic send_code(input logic [7:0] xy);
    send(8'hFF); send(8'h00); send(8'h00); send(xy);
  endtask

  task automatic clear_counts();
    n_sav = 0; n_eav = 0; n_pv = 0; n_prot = 0; n_seq = 0;
    got_pix.delete();
  endtask

  // Pixels are 01, 02, ... so the captured sequence is easy to predict.
  task automatic send_line(input logic [7:0] sav, input int npix, input logic [7:0] eav);
    send_code(sav);
    for (int i = 1; i <= npix; i++) send(8'(i));
    send_code(eav);
  endtask

  task automatic check_pix_seq(input string tag, input int npix);
    chk({tag, "_npix"}, 32'(got_pix.size()), 32'(npix));
    for (int i = 0; i < got_pix.size() && i < npix; i++) chk(tag, 32'(got_pix[i]), 32'(i + 1));
  endtask

  function automatic logic [7:0] pick_xy(input bit eav);
    logic [7:0] b;
    case ($urandom_range(0, 3))
      0: b = eav ? 8'h9D : 8'h80;
      1: b = eav ? 8'hB6 : 8'hAB;
      2: b = eav ? 8'hDA : 8'hC7;
      default: b = eav ? 8'hF1 : 8'hEC;
    endcase
    if ($urandom_range(0, 7) == 0) b = 8'($urandom_range(0, 255));
    else if ($urandom_range(0, 1) == 0) b = eav ? 8'h9D : 8'h80;
    return b;
  endfunction

  function automatic logic [7:0] rand_pix();
    if ($urandom_range(0, 15) == 0) return 8'h00;
    return 8'($urandom_range(1, 254));
  endfunction

  initial begin
    int npix;
    rsted_n    = 1'b0;
    bus.din    = 8'h80;
    bus.din_en = 1'b1;
    model_reset();
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    chk("rst_vd", 32'(bus.vd), 32'd1);
    chk("rst_hd", 32'(bus.hd), 32'd0);
    chk("rst_locked", 32'(bus.locked), 32'd0);
    @(negedge clk);
    rsted_n = 1'b1;

    // Single nominal line
    send_line(8'h80, 7, 8'h9D);
    chk("t1_sav_cnt", 32'(n_sav), 32'd1);
    check_pix_seq("t1_pix", 7);
    chk("t1_eav", 32'(bus.eav_pulse), 32'd1);
    chk("t1_line_len", 32'(bus.line_len), 32'd7);
    chk("t1_len_err", 32'(bus.len_err), 32'd0);
    chk("t2_lock_after1", 32'(bus.locked), 32'd0);

    // Lock on the second good line
    send_line(8'h80, 7, 8'h9D);
    chk("t2_lock_after2", 32'(bus.locked), 32'd1);
    send_line(8'h80, 7, 8'h9D);
    chk("t2_line_cnt", 32'(bus.line_cnt), 32'd3);
    chk("t2_lock_after3", 32'(bus.locked), 32'd1);

    // Bad protection
    clear_counts();
    send_code(8'h81);
    chk("t3_prot_err", 32'(bus.prot_err), 32'd1);
    chk("t3_no_sav", 32'(n_sav), 32'd0);
    chk("t3_hd", 32'(bus.hd), 32'd0);
    chk("t3_locked", 32'(bus.locked), 32'd0);

    // Short line
    send_line(8'h80, 5, 8'h9D);
    chk("t4_eav", 32'(bus.eav_pulse), 32'd1);
    chk("t4_len_err", 32'(bus.len_err), 32'd1);
    chk("t4_line_len", 32'(bus.line_len), 32'd5);
    chk("t4_locked", 32'(bus.locked), 32'd0);

    // Broken preamble inside the active window
    send_code(8'h80);
    send(8'h01); send(8'h02); send(8'h03);
    send(8'hFF); send(8'h00); send(8'h05);
    chk("t5_seq_err", 32'(bus.seq_err), 32'd1);
    chk("t5_hd", 32'(bus.hd), 32'd0);
    clear_counts();
    for (int i = 0; i < 4; i++) send(8'(8'h10 + i));
    chk("t5_no_pix", 32'(n_pv), 32'd0);
    send_line(8'h80, 7, 8'h9D);
    check_pix_seq("t5_recover_pix", 7);

    // Reset in the middle of a line
    send_code(8'h80);
    send(8'h01); send(8'h02);
    @(negedge clk);
    rsted_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_mid_hd", 32'(bus.hd), 32'd0);
    chk("rst_mid_vd", 32'(bus.vd), 32'd1);
    @(negedge clk);
    rsted_n = 1'b1;
    clear_counts();
    send_line(8'h80, 7, 8'h9D);
    chk("rst_mid_sav", 32'(n_sav), 32'd1);
    chk("rst_mid_line_len", 32'(bus.line_len), 32'd7);

    // Same line with din_en toggling every cycle, then a field change
    gap_mode = 1;
    clear_counts();
    send_line(8'h80, 7, 8'h9D);
    chk("t6_sav_cnt", 32'(n_sav), 32'd1);
    chk("t6_eav_cnt", 32'(n_eav), 32'd1);
    check_pix_seq("t6_pix", 7);
    chk("t6_line_len", 32'(bus.line_len), 32'd7);
    send_code(8'hF1);
    chk("t6_eav", 32'(bus.eav_pulse), 32'd1);
    chk("t6_field", 32'(bus.field), 32'd1);
    chk("t6_vd", 32'(bus.vd), 32'd1);
    chk("t6_line_cnt", 32'(bus.line_cnt), 32'd0);
    drive(8'h00, 1'b0);
    chk("t6_eav_one_cycle", 32'(bus.eav_pulse), 32'd0);

    // Randomized streams checked cycle by cycle against the model
    for (int seg = 0; seg < 150; seg++) begin
      gap_mode = int'($urandom_range(0, 2));
      send_code(pick_xy(1'b0));
      npix = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 9)) : 7;
      for (int i = 0; i < npix; i++) send(rand_pix());
      if ($urandom_range(0, 7) == 0) begin
        send(8'hFF);
        send(($urandom_range(0, 1) == 0) ? 8'h00 : 8'h05);
        send(rand_pix());
      end
      send_code(pick_xy(1'b1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bt656_sync_decoder.md
Name: bt656_sync_decoder

Overview:
Receive side of the team's 8-bit BT.656-style timing-reference stream (the FF 00 00 XY SAV/EAV framing with F/V/H and protection bits).
- Finds and validates timing codes.
- Recovers the F, V and H flags.
- Outputs active-video pixels with a valid strobe.
- Measures active line length and counts lines per field, and reports lock and errors.
- Sits between the video byte source (sample generator or external decoder chip) and downstream capture/line-buffer logic.

Parameters:
ACTIVE_LEN, 7, expected number of pixel bytes between SAV and EAV.
LOCK_LINES, 2, consecutive good lines required to assert locked.
CNT_W, 16, width of the pixel, line and length counters.

Ports:
clk  in  1  sole clock, rising edge.
rsted_n  in  1  asynchronous active-low reset.
din  in  8  video byte stream.
din_en  in  1  qualifies din; when low, nothing advances.
pix  out  8  active pixel byte.
pix_valid  out  1  pix is an active-video pixel.
hd  out  1  high from SAV XY to EAV FF (H-active window).
vd  out  1  last decoded V flag (1 = vertical blanking).
field  out  1  last decoded F flag.
sav_pulse  out  1  one-cycle pulse on each accepted SAV.
eav_pulse  out  1  one-cycle pulse on each accepted EAV.
prot_err  out  1  one-cycle pulse: XY protection mismatch or XY[7]=0.
seq_err  out  1  one-cycle pulse: preamble broken inside the active window.
len_err  out  1  one-cycle pulse with eav_pulse when line_len != ACTIVE_LEN (only when the line was active, V=0).
line_len  out  CNT_W  pixel count of the last completed active line.
line_cnt  out  CNT_W  EAVs since the last F change.
locked  out  1  stream lock indicator.

Behaviour:
Reset and timing
- Reset (asynchronous, active-low): all outputs 0, except vd=1. Preamble FSM returns to SEEK; counters clear.
- All outputs are registered. Logic advances only on din_en=1; pulses last exactly one clk cycle.

Preamble FSM (states SEEK, FF1, Z1, Z2)
- SEEK: FF goes to FF1.
- FF1: 00 goes to Z1; FF stays in FF1; any other byte goes to SEEK.
- Z1: 00 goes to Z2; otherwise SEEK (FF goes to FF1).
- Z2: the next byte is XY; the FSM returns to SEEK.

XY check
- Required protection: P3=V^H, P2=F^H, P1=F^V, P0=F^V^H.
- Valid codes: 80, 9D, AB, B6, C7, DA, EC, F1.
- An invalid XY, or XY[7]=0, gives prot_err. Flags stay unchanged and no sav/eav pulse is generated.

Valid XY decoding
- H=0 (SAV): sav_pulse; hd=1; clear the pixel counter; update vd and field.
- H=1 (EAV): eav_pulse; hd=0; latch line_len from the pixel counter; len_err check; line_cnt+1; update vd and field.
- A change of field resets line_cnt to 0 on that EAV instead of incrementing.

Pixel path
- pix_valid=1 when hd=1, vd=0, and din is neither FF nor 00.
- pix = din registered, so latency is 1 clk.
- The pixel counter increments with each pix_valid and saturates at all-ones.

Active-window breaks
- A din of FF while hd=1 clears hd immediately; pix_valid stays 0 for that byte.
- If that preamble then fails, or FF/00 is followed by a non-code: seq_err pulses and hd stays 0 until the next SAV.
- A 00 byte inside the window is discarded silently.

Lock
- Good line: EAV with vd=0 and no len_err.
- The good-line counter saturates at LOCK_LINES.
- locked=1 when the counter reaches LOCK_LINES.
- Any prot_err, seq_err or len_err clears both the counter and locked in the same cycle.
- Blanking lines (V=1) neither count toward lock nor break it.

Simultaneous events
- If an error and a valid code occur in the same cycle, the error takes precedence for locked.
- The counter saturation rule applies to every counter.
- Reset in mid-preamble or mid-line: immediate return to reset values; the first valid SAV resumes decoding.

Decomposition:
- Shared package bt656_pkg:
  - preamble constants: FF, 00 and the 8 valid XY codes;
  - FSM state enum;
  - protection-bit function fvh_to_p(f,v,h).
- One natural sub-module, bt656_xy_check: combinational XY validation and F/V/H extraction. Shared later with the encoder.
- Everything else stays in the top.

Test Plan:
1. Reset with din=80 idle → vd=1, hd=0, locked=0. Feed FF 00 00 80, then pixels 01..07, then FF 00 00 9D →
   - sav_pulse, then 7 pix_valid with pix 01..07;
   - eav_pulse with line_len=7, len_err=0.
2. Three such lines with V=0 → locked rises on the 2nd EAV; line_cnt=3.
3. SAV XY=0x81 (bad protection) → prot_err, no sav_pulse, hd stays 0, locked drops.
4. Active line with 5 pixels → eav_pulse with len_err=1, line_len=5, locked=0.
5. FF 00 05 inside active window → seq_err, hd=0, no further pix_valid until the next SAV.
6. din_en toggled 1/0 every cycle through case 1 → identical outputs, with pulses one cycle each; EAV XY=F1 → field=1, vd=1, and line_cnt resets to 0.
